// File: rtl/bus_pkg.sv
// bus_pkg: op codes, sequencer states and legal-request mask shared by the bus sequencer
package bus_pkg;
  typedef enum logic [3:0] {
    CCRD  = 4'd1,
    CCWR  = 4'd2,
    DCRD  = 4'd3,
    DCWR  = 4'd4,
    FETCH = 4'd8,
    DRD   = 4'd9,
    DWR   = 4'd10,
    RDMWR = 4'd11,
    BTRWR = 4'd12,
    BTRRD = 4'd13,
    BICLR = 4'd14,
    BIRD  = 4'd15
  } bus_op_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} seq_state_t;
  localparam logic [15:0] LEGAL_MASK = 16'hFF1E;
endpackage

// File: rtl/bus_seq_if.sv
// bus_seq_if: request/ack bundle between op sources, sequencer and arbiter
interface bus_seq_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  request;
  logic [15:0] ack;
  logic        busy;
  logic        err;
  logic        bad_req;
  modport master (input req, done, output request, ack, busy, err, bad_req);
  modport slave  (output req, done, input request, ack, busy, err, bad_req);
endinterface

// File: rtl/bus_prio_pick.sv
// bus_prio_pick: fixed-priority selection of one legal pending op code
module bus_prio_pick
  import bus_pkg::*;
(
  input  logic [15:0] valid,
  output bus_op_t     winner,
  output logic        any_valid
);
  // RDMWR deliberately outranks the BTR ops so read-modify-write is never starved by them
  always_comb begin
    winner = valid[15] ? BIRD  :
             valid[14] ? BICLR :
             valid[11] ? RDMWR :
             valid[13] ? BTRRD :
             valid[12] ? BTRWR :
             valid[10] ? DWR   :
             valid[9]  ? DRD   :
             valid[8]  ? FETCH :
             valid[4]  ? DCWR  :
             valid[3]  ? DCRD  :
             valid[2]  ? CCWR  : CCRD;
    any_valid = |valid;
  end
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: picks one pending bus op, holds its code until done, then acks (watchdog under BUS_TIMEOUT_EN)
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 120
) (
  input logic       clk,
  input logic       reset,
  bus_seq_if.master bus
);
  seq_state_t state, state_nx;
  logic [3:0] code;
  bus_op_t    winner;
  logic       any_valid;
  logic       timeout;
  logic       to_flag;
  bus_prio_pick u_pick (
    .valid    (bus.req & LEGAL_MASK),
    .winner   (winner),
    .any_valid(any_valid)
  );
`ifdef BUS_TIMEOUT_EN
  logic [6:0] wd;
  assign timeout = state == ACTIVE && !bus.done && wd == 7'(TIMEOUT - 1);
  // wd sits at 0 outside ACTIVE, so it is already cleared on entry
  always_ff @(posedge clk)
    if (reset) wd <= '0;
    else wd <= state == ACTIVE ? wd + 7'd1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state   <= IDLE;
      code    <= '0;
      to_flag <= 1'b0;
    end else begin
      state   <= state_nx;
      to_flag <= timeout;
      if (state == IDLE && any_valid) code <= winner;
    end
  always_comb
    state_nx = state == IDLE   ? (any_valid ? ACTIVE : IDLE) :
               state == ACTIVE ? ((bus.done || timeout) ? RELEASE : ACTIVE) : IDLE;
  always_comb begin
    bus.request = state == ACTIVE ? code : 4'd0;
    bus.ack     = state == RELEASE ? 16'd1 << code : 16'd0;
    bus.busy    = state != IDLE;
    bus.err     = state == RELEASE && to_flag;
    bus.bad_req = |(bus.req & ~LEGAL_MASK);
  end
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed self-checking bench for bus_sequencer
module tb_bus_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bus_seq_if bus ();
  bus_sequencer #(.TIMEOUT(120)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.done = 1'b0;
    cyc();
    cyc();
    chk("rst_request", 32'(bus.request), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    reset = 1'b0;
    cyc();
    bus.req = 16'h0004;
    cyc();
    chk("t1_request_c1", 32'(bus.request), 2);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_ack_c1", 32'(bus.ack), 0);
    cyc();
    chk("t1_request_c2", 32'(bus.request), 2);
    cyc();
    chk("t1_request_c3", 32'(bus.request), 2);
    bus.done = 1'b1;
    cyc();
    chk("t1_rel_request", 32'(bus.request), 0);
    chk("t1_ack", 32'(bus.ack), 32'h0004);
    chk("t1_rel_busy", 32'(bus.busy), 1);
    chk("t1_err", 32'(bus.err), 0);
    bus.done = 1'b0;
    bus.req = '0;
    cyc();
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_idle_ack", 32'(bus.ack), 0);
    bus.req = 16'h0104;
    cyc();
    chk("t2_request_fetch", 32'(bus.request), 8);
    bus.done = 1'b1;
    cyc();
    chk("t2_ack_fetch", 32'(bus.ack), 32'h0100);
    chk("t2_gap1", 32'(bus.request), 0);
    bus.done = 1'b0;
    bus.req = 16'h0004;
    cyc();
    chk("t2_gap2", 32'(bus.request), 0);
    chk("t2_gap2_ack", 32'(bus.ack), 0);
    cyc();
    chk("t2_request_ccwr", 32'(bus.request), 2);
    bus.done = 1'b1;
    cyc();
    chk("t2_ack_ccwr", 32'(bus.ack), 32'h0004);
    bus.done = 1'b0;
    bus.req = '0;
    cyc();
    bus.req = 16'h0020;
    #1;
    chk("t3_bad_req", 32'(bus.bad_req), 1);
    cyc();
    chk("t3_request", 32'(bus.request), 0);
    chk("t3_busy", 32'(bus.busy), 0);
    cyc();
    chk("t3_ack", 32'(bus.ack), 0);
    bus.req = '0;
    #1;
    chk("t3_bad_clear", 32'(bus.bad_req), 0);
    bus.req = 16'h0800;
    cyc();
    chk("t4_request_rdmwr", 32'(bus.request), 11);
    bus.req = 16'h8800;
    cyc();
    chk("t4_no_preempt", 32'(bus.request), 11);
    reset = 1'b1;
    cyc();
    chk("t4_rst_request", 32'(bus.request), 0);
    chk("t4_rst_ack", 32'(bus.ack), 0);
    chk("t4_rst_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    bus.req = '0;
    cyc();
    chk("t4_post_ack", 32'(bus.ack), 0);
    chk("t4_post_err", 32'(bus.err), 0);
    bus.done = 1'b1;
    cyc();
    chk("t6_idle_done_busy", 32'(bus.busy), 0);
    chk("t6_idle_done_ack", 32'(bus.ack), 0);
    bus.done = 1'b0;
    bus.req = 16'h8001;
    #1;
    chk("t6_bad_req", 32'(bus.bad_req), 1);
    cyc();
    chk("t6_request", 32'(bus.request), 15);
    cyc();
    chk("t6_hold", 32'(bus.request), 15);
    chk("t6_no_ack", 32'(bus.ack), 0);
    bus.done = 1'b1;
    cyc();
    chk("t6_ack", 32'(bus.ack), 32'h8000);
    chk("t6_err", 32'(bus.err), 0);
    bus.done = 1'b0;
    bus.req = 16'h0001;
    cyc();
    cyc();
    chk("t6_illegal_only", 32'(bus.request), 0);
    chk("t6_illegal_busy", 32'(bus.busy), 0);
    bus.req = '0;
    cyc();
`ifdef BUS_TIMEOUT_EN
    bus.req = 16'h0200;
    for (int i = 1; i <= 120; i++) begin
      cyc();
      chk($sformatf("t5_hold_%0d", i), 32'(bus.request), 9);
    end
    cyc();
    chk("t5_to_ack", 32'(bus.ack), 32'h0200);
    chk("t5_to_err", 32'(bus.err), 1);
    chk("t5_to_request", 32'(bus.request), 0);
    bus.req = '0;
    cyc();
    chk("t5_err_pulse", 32'(bus.err), 0);
    bus.req = 16'h0200;
    for (int i = 1; i <= 120; i++) begin
      cyc();
      if (i == 120) bus.done = 1'b1;
    end
    cyc();
    chk("t5_race_ack", 32'(bus.ack), 32'h0200);
    chk("t5_race_err", 32'(bus.err), 0);
    bus.done = 1'b0;
    bus.req = '0;
    cyc();
`else
    bus.req = 16'h0200;
    for (int i = 1; i <= 130; i++) cyc();
    chk("nto_hold_request", 32'(bus.request), 9);
    chk("nto_hold_ack", 32'(bus.ack), 0);
    bus.done = 1'b1;
    cyc();
    chk("nto_ack", 32'(bus.ack), 32'h0200);
    chk("nto_err", 32'(bus.err), 0);
    bus.done = 1'b0;
    bus.req = '0;
    cyc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
